fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Front-end controller that drives the combinational instruction ROM.
- Owns the program counter, issues one word-aligned fetch address per cycle, and captures each returned instruction with its PC into a small queue toward decode.
- Handles backpressure, redirect/flush from branch resolution, and fetch faults for out-of-range or misaligned PCs.

Parameters:
- IMEM_SIZE, 1024, ROM size in bytes; power of two, >4.
- QDEPTH, 4, fetch queue entries; power of two, >=2.
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk  input  1  clock; all state on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- imem_addr  output  32  byte address to instruction ROM; always equals the current PC.
- imem_instr  input  32  combinational ROM data for imem_addr.
- redirect_valid  input  1  flush and redirect request, single-cycle pulse.
- redirect_pc  input  32  new PC accompanying redirect_valid.
- out_valid  output  1  queue head is valid.
- out_ready  input  1  decode accepts the head this cycle.
- out_pc  output  32  PC of the queue head.
- out_instr  output  32  instruction of the queue head.
- fault  output  1  sequencer in FAULT state.
- occupancy  output  $clog2(QDEPTH)+1  current queue count.

Behaviour:
- Reset (rst_n=0, async) sets:
  - PC=RESET_PC, queue empty, state=FETCH.
  - out_valid=0, fault=0, occupancy=0.
  - out_pc and out_instr = 0.
- States:
  - FETCH: normal operation, one fetch attempt per cycle.
  - FAULT: no enqueue; PC holds; fault=1.
- Enqueue condition, in FETCH only:
  - PC in bounds: PC+3 < IMEM_SIZE.
  - And queue has room: count<QDEPTH, or a dequeue occurs this cycle.
  - Enqueued entry is {PC, imem_instr}; PC<=PC+4 in the same cycle.
- Stall:
  - If the queue is full and there is no dequeue, PC holds and imem_addr is stable.
  - No entry is dropped or duplicated.
- Dequeue: out_valid && out_ready pops the head on the clock edge.
- Simultaneous enqueue and dequeue:
  - Count is unchanged.
  - This is legal at full and at empty. At empty, the new entry becomes visible the next cycle; there is no bypass.
- Latency: the instruction at PC P is presented on out_* exactly 1 cycle after imem_addr=P, when it is enqueued.
- PC arithmetic: 32-bit; wrap past 2^32 is not special-cased, because the bounds check triggers first.
- Out of bounds: in FETCH with PC+3 >= IMEM_SIZE:
  - No enqueue; next state is FAULT.
  - Already-queued entries still drain normally.
- Redirect: redirect_valid=1 has highest priority in any state.
  - Queue flushed to empty and any same-cycle dequeue is discarded. out_valid is 0 the next cycle.
  - No enqueue that cycle.
  - If redirect_pc[1:0]==0 and in bounds: PC<=redirect_pc, next state FETCH.
  - Otherwise: PC<=redirect_pc, next state FAULT, fault=1 from the next cycle.
- FAULT exit: only by a valid redirect or by reset.
- Reset asserted mid-operation: immediate return to reset values regardless of state or queue contents.
- imem_addr is never misaligned while in FETCH.

Decomposition:
- Package fetch_pkg holds:
  - typedef fetch_entry_t: packed struct {pc[31:0], instr[31:0]}.
  - enum fetch_state_t {FETCH, FAULT}.
  - localparam INSTR_BYTES=4.
- Sub-module fetch_queue:
  - Parameterised circular FIFO of fetch_entry_t with head/tail pointers and a count.
  - Ports: enq, deq, flush, full, empty, count, head.
  - Async active-low reset.
- fetch_sequencer contains the PC register, the FSM, and the bounds and alignment checks.

Test Plan:
- Streaming after reset:
  - Stimulus: release rst_n with out_ready=1 held.
  - Required: imem_addr = 0,4,8,... on successive cycles; out_pc = 0,4,8,... one cycle behind; out_instr matches ROM words 0,1,2.
- Backpressure:
  - Stimulus: hold out_ready=0, QDEPTH=4.
  - Required: occupancy reaches 4 by cycle 4, then imem_addr holds at 16.
  - Then assert out_ready=1: out_pc 0,4,8,12,16 arrive in order with no gaps or duplicates.
- Redirect while full:
  - Stimulus: queue holds 4 entries; pulse redirect_valid with redirect_pc=0x40 together with out_ready=1.
  - Required: next cycle out_valid=0, occupancy=0, imem_addr=0x40; the cycle after, out_pc=0x40.
- End of memory:
  - Stimulus: redirect_pc=IMEM_SIZE-8 (0x3F8).
  - Required: entries 0x3F8 and 0x3FC are enqueued, then fault=1 with imem_addr held at 0x400.
  - The queue still drains both entries.
- Misaligned redirect then recovery:
  - Stimulus: redirect_pc=0x22, then redirect_pc=0x20.
  - Required: fault=1 and no enqueues after the first; after the second, fault=0 and out_pc=0x20 one cycle later.
- Asynchronous reset mid-stream:
  - Stimulus: drop rst_n between clock edges while the queue holds 3 entries.
  - Required: out_valid=0, occupancy=0 and imem_addr=RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: queue entry layout and sequencer states.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc, instr} entries between the sequencer and decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enq,
  input  fetch_entry_t       enq_data,
  input  logic               deq,
  input  logic               flush,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count,
  output fetch_entry_t       head
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_do_deq;
  logic w_do_enq;

  // Flush wins over both sides; an enqueue at full is only taken alongside a pop.
  assign w_do_deq = deq && !flush && (r_count != '0);
  assign w_do_enq = enq && !flush && (!full || w_do_deq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_deq) r_head <= r_head + PTR_W'(1);
      if (w_do_enq) r_tail <= r_tail + PTR_W'(1);
      case ({w_do_enq, w_do_deq})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_enq) r_mem[r_tail] <= enq_data;
  end

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_head];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch front end: owns the PC, drives the ROM address, and queues {pc, instr} toward decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          IMEM_SIZE = 1024,
  parameter int          QDEPTH    = 4,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_instr,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic                       fault,
  output logic [$clog2(QDEPTH):0]    occupancy
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic         r_fault;

  logic                     w_pc_in_bounds;
  logic                     w_redir_ok;
  logic                     w_enq;
  logic                     w_deq;
  logic                     w_full;
  logic                     w_empty;
  logic [$clog2(QDEPTH):0]  w_count;
  fetch_entry_t             w_head;
  fetch_entry_t             w_new_entry;

  // Bounds are evaluated in 33 bits so a PC near 2^32 cannot wrap into range.
  assign w_pc_in_bounds = ({1'b0, r_pc} + 33'(INSTR_BYTES - 1)) < 33'(IMEM_SIZE);
  assign w_redir_ok     = (redirect_pc[1:0] == 2'b00) &&
                          (({1'b0, redirect_pc} + 33'(INSTR_BYTES - 1)) < 33'(IMEM_SIZE));

  assign w_deq = !w_empty && out_ready && !redirect_valid;
  assign w_enq = !redirect_valid && (r_state == FETCH) && w_pc_in_bounds && (!w_full || w_deq);

  assign w_new_entry = '{pc: r_pc, instr: imem_instr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc;
      if (w_redir_ok) begin
        r_state <= FETCH;
        r_fault <= 1'b0;
      end else begin
        r_state <= FAULT;
        r_fault <= 1'b1;
      end
    end else begin
      case (r_state)
        FETCH: begin
          if (!w_pc_in_bounds) begin
            r_state <= FAULT;
            r_fault <= 1'b1;
          end else if (w_enq) begin
            r_pc <= r_pc + 32'(INSTR_BYTES);
          end
        end
        FAULT: begin
          r_state <= FAULT;
          r_fault <= 1'b1;
        end
        default: begin
          r_state <= FAULT;
          r_fault <= 1'b1;
        end
      endcase
    end
  end

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .enq      (w_enq),
    .enq_data (w_new_entry),
    .deq      (w_deq),
    .flush    (redirect_valid),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_count),
    .head     (w_head)
  );

  // Head fields read as zero whenever nothing is queued, including straight out of reset.
  assign imem_addr = r_pc;
  assign out_valid = !w_empty;
  assign out_pc    = w_empty ? 32'h0 : w_head.pc;
  assign out_instr = w_empty ? 32'h0 : w_head.instr;
  assign fault     = r_fault;
  assign occupancy = w_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: queue-based reference model plus directed literal checks.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int          IMEM_SIZE = 1024;
  localparam int          QDEPTH    = 4;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fault;
  logic [$clog2(QDEPTH):0] occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]  m_pc;
  logic         m_fault;
  fetch_entry_t m_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_instr = rom_word(imem_addr);

  fetch_sequencer #(
    .IMEM_SIZE(IMEM_SIZE),
    .QDEPTH   (QDEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fault          (fault),
    .occupancy      (occupancy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic in_b(input logic [31:0] a);
    return ({1'b0, a} + 33'd3) < 33'(IMEM_SIZE);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc    = RESET_PC;
    m_fault = 1'b0;
  endtask

  task automatic model_step(input logic rv, input logic [31:0] rpc, input logic rdy);
    logic         deq;
    logic         enq;
    fetch_entry_t e;
    if (rv) begin
      m_q.delete();
      m_pc    = rpc;
      m_fault = !((rpc[1:0] == 2'b00) && in_b(rpc));
    end else begin
      deq = (m_q.size() != 0) && rdy;
      enq = !m_fault && in_b(m_pc) && ((m_q.size() < QDEPTH) || deq);
      if (deq) void'(m_q.pop_front());
      if (enq) begin
        e.pc    = m_pc;
        e.instr = rom_word(m_pc);
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end else if (!m_fault && !in_b(m_pc)) begin
        m_fault = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    chk("imem_addr", imem_addr, m_pc);
    chk("fault", 32'(fault), 32'(m_fault));
    chk("occupancy", 32'(occupancy), 32'(m_q.size()));
    chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("out_pc", out_pc, m_q[0].pc);
      chk("out_instr", out_instr, m_q[0].instr);
    end
  endtask

  task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    model_step(rv, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    check_model();
  endtask

  task automatic rand_cycles(input int n);
    logic        rv;
    logic        rdy;
    logic [31:0] rpc;
    int          sel;
    for (int i = 0; i < n; i++) begin
      rv  = ($urandom_range(99) < 4);
      rdy = ($urandom_range(99) < 65);
      sel = int'($urandom_range(3));
      case (sel)
        0:       rpc = 32'($urandom_range(IMEM_SIZE / 4 - 1)) * 32'd4;
        1:       rpc = 32'(IMEM_SIZE) - 32'd4 * 32'($urandom_range(1, 4));
        2:       rpc = (32'($urandom_range(IMEM_SIZE / 4 - 1)) * 32'd4) | 32'($urandom_range(1, 3));
        default: rpc = $urandom;
      endcase
      cycle(rv, rpc, rdy);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_occ", 32'(occupancy), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    rst_n = 1'b1;

    // Streaming with decode always ready.
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b0, 32'h0, 1'b1);
      chk("stream_addr", imem_addr, 32'(4 * k));
      chk("stream_pc", out_pc, 32'(4 * (k - 1)));
      chk("stream_instr", out_instr, rom_word(32'(4 * (k - 1))));
    end

    // Backpressure until full, then drain in order.
    cycle(1'b1, 32'h0, 1'b0);
    repeat (4) cycle(1'b0, 32'h0, 1'b0);
    chk("bp_occ_full", 32'(occupancy), 32'd4);
    chk("bp_addr_hold", imem_addr, 32'd16);
    cycle(1'b0, 32'h0, 1'b0);
    chk("bp_addr_still", imem_addr, 32'd16);
    for (int i = 0; i <= 4; i++) begin
      chk("bp_order", out_pc, 32'(4 * i));
      cycle(1'b0, 32'h0, 1'b1);
    end

    // Redirect while full with a same-cycle dequeue.
    cycle(1'b1, 32'h0, 1'b0);
    repeat (4) cycle(1'b0, 32'h0, 1'b0);
    chk("rf_occ_before", 32'(occupancy), 32'd4);
    cycle(1'b1, 32'h40, 1'b1);
    chk("rf_valid", 32'(out_valid), 32'h0);
    chk("rf_occ", 32'(occupancy), 32'h0);
    chk("rf_addr", imem_addr, 32'h40);
    cycle(1'b0, 32'h0, 1'b1);
    chk("rf_out_pc", out_pc, 32'h40);

    // End of memory: two entries, then fault with PC parked past the end.
    cycle(1'b1, 32'h3F8, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 1'b0);
    chk("eom_fault", 32'(fault), 32'h1);
    chk("eom_addr", imem_addr, 32'h400);
    chk("eom_occ", 32'(occupancy), 32'd2);
    chk("eom_head0", out_pc, 32'h3F8);
    cycle(1'b0, 32'h0, 1'b1);
    chk("eom_head1", out_pc, 32'h3FC);
    cycle(1'b0, 32'h0, 1'b1);
    chk("eom_drained", 32'(occupancy), 32'h0);
    chk("eom_fault_hold", 32'(fault), 32'h1);

    // Misaligned redirect, then recovery.
    cycle(1'b1, 32'h22, 1'b1);
    chk("mis_fault", 32'(fault), 32'h1);
    repeat (2) cycle(1'b0, 32'h0, 1'b1);
    chk("mis_no_enq", 32'(occupancy), 32'h0);
    chk("mis_addr_hold", imem_addr, 32'h22);
    cycle(1'b1, 32'h20, 1'b1);
    chk("rec_fault", 32'(fault), 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("rec_valid", 32'(out_valid), 32'h1);
    chk("rec_out_pc", out_pc, 32'h20);

    rand_cycles(1500);

    // Asynchronous reset between clock edges with three queued entries.
    cycle(1'b1, 32'h0, 1'b0);
    repeat (3) cycle(1'b0, 32'h0, 1'b0);
    chk("ar_occ_before", 32'(occupancy), 32'd3);
    chk("ar_addr_before", imem_addr, 32'd12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'h0);
    chk("ar_occ", 32'(occupancy), 32'h0);
    chk("ar_addr", imem_addr, RESET_PC);
    chk("ar_fault", 32'(fault), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_model();
    rand_cycles(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
